// File: rtl/serv_decode_q_if.sv
// Fetch/execute handshake bundle for serv_decode_q: instruction word and push
// request in from the ibus, valid/next handshake toward serv_state.
interface serv_decode_q_if;
    logic [31:2] i_wb_rdt;
    logic        i_wb_en;
    logic        o_ready;
    logic        o_valid;
    logic        i_next;

    modport master (
        output i_wb_rdt,
        output i_wb_en,
        output i_next,
        input  o_ready,
        input  o_valid
    );

    modport slave (
        input  i_wb_rdt,
        input  i_wb_en,
        input  i_next,
        output o_ready,
        output o_valid
    );
endinterface

// File: rtl/serv_decode_q.sv
// Queued SERV instruction decoder: a DEPTH-entry FIFO of raw decode fields with
// combinational decode of the head entry. Define SERV_DECODE_BYPASS_EN to let an
// empty queue present the incoming word in the same cycle.
module serv_decode_q #(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            i_rst_n,
    serv_decode_q_if.slave  bus,
    output logic [AW:0]     o_level,
    output logic            o_ovf,
    output logic [4:0]      o_opcode,
    output logic [2:0]      o_funct3,
    output logic            o_mem_op,
    output logic            o_shift_op,
    output logic            o_slt_op,
    output logic            o_branch_op,
    output logic            o_rd_op,
    output logic            o_alu_sub,
    output logic            o_csr_op,
    output logic            o_mem_cmd,
    output logic            o_op_b_source
);

    localparam int            EW       = 13;
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic [EW-1:0] wb_entry;
    logic [EW-1:0] head;
    logic          full, empty;
    logic          push, pop, ovf_set;
    logic          byp_take;
    logic          unused_bits;

    // Entry layout: {opcode[6:2], funct3, bit30, bit26, bit22, bit21, bit20}
    assign wb_entry = {bus.i_wb_rdt[6:2], bus.i_wb_rdt[14:12], bus.i_wb_rdt[30],
                       bus.i_wb_rdt[26], bus.i_wb_rdt[22], bus.i_wb_rdt[21],
                       bus.i_wb_rdt[20]};

    assign full  = (cnt_q == FULL_LVL);
    assign empty = (cnt_q == '0);

`ifdef SERV_DECODE_BYPASS_EN
    logic bypass;
    assign bypass      = empty & bus.i_wb_en;
    assign byp_take    = bypass & bus.i_next;
    assign head        = bypass ? wb_entry : mem_q[rptr_q];
    assign bus.o_valid = !empty | bypass;
`else
    assign byp_take    = 1'b0;
    assign head        = mem_q[rptr_q];
    assign bus.o_valid = !empty;
`endif

    // A bypassed word consumed in its arrival cycle never touches the queue.
    assign pop     = bus.i_next & !empty;
    assign push    = bus.i_wb_en & (!full | pop) & !byp_take;
    assign ovf_set = bus.i_wb_en & full & !pop;

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q | ovf_set;
        if (push)
            wptr_d = wptr_q + PTR_ONE;
        if (pop)
            rptr_d = rptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage is intentionally not reset; contents are qualified by the count.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= wb_entry;
    end

    assign bus.o_ready = !full;
    assign o_level     = cnt_q;
    assign o_ovf       = ovf_q;

    logic [4:0] op;
    logic [2:0] f;
    logic       i30;

    assign op  = head[12:8];
    assign f   = head[7:5];
    assign i30 = head[4];

    assign o_opcode      = op;
    assign o_funct3      = f;
    assign o_mem_op      = !op[4] & !op[2] & !op[0];
    assign o_shift_op    = !op[4] & op[2] & !op[0] & (f[1:0] == 2'b01);
    assign o_slt_op      = !op[4] & op[2] & !op[0] & (f[2:1] == 2'b01);
    assign o_branch_op   = op[4] & !op[2];
    assign o_rd_op       = op[2] | (op[4] & op[0]) | (!op[3] & !op[0]);
    assign o_alu_sub     = (!f[2] & (f[0] | (op[3] & i30))) | f[1] | op[4];
    assign o_csr_op      = op[4] & op[2] & (f != 3'b000);
    assign o_mem_cmd     = op[3];
    assign o_op_b_source = op[3];

    // Fields carried for downstream decode growth but not used by these controls.
    assign unused_bits = ^{head[3:0], bus.i_wb_rdt[31], bus.i_wb_rdt[29:27],
                           bus.i_wb_rdt[25:23], bus.i_wb_rdt[19:15],
                           bus.i_wb_rdt[11:7]};

endmodule

// File: tb/tb_serv_decode_q.sv
// Directed bench for serv_decode_q (DEPTH=2): decode of known RV32I words, FIFO
// order across wrap, full/overflow behaviour, async reset and same-cycle path.
module tb_serv_decode_q;

`ifdef SERV_DECODE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [31:0] W_ADDI = 32'h00500093;
    localparam logic [31:0] W_SUB  = 32'h402081B3;
    localparam logic [31:0] W_LW   = 32'h0000A103;
    localparam logic [31:0] W_BEQ  = 32'h00208463;
    localparam logic [31:0] W_SLLI = 32'h00109093;
    localparam logic [31:0] W_SLTI = 32'h0010A093;
    localparam logic [31:0] W_CSR  = 32'h30001073;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] level;
    logic       ovf;
    logic [4:0] opcode;
    logic [2:0] funct3;
    logic       mem_op, shift_op, slt_op, branch_op, rd_op;
    logic       alu_sub, csr_op, mem_cmd, op_b_source;

    int n_chk  = 0;
    int n_fail = 0;

    serv_decode_q_if dq_if ();

    serv_decode_q #(.DEPTH(2)) dut (
        .clk           (clk),
        .i_rst_n       (rst_n),
        .bus           (dq_if),
        .o_level       (level),
        .o_ovf         (ovf),
        .o_opcode      (opcode),
        .o_funct3      (funct3),
        .o_mem_op      (mem_op),
        .o_shift_op    (shift_op),
        .o_slt_op      (slt_op),
        .o_branch_op   (branch_op),
        .o_rd_op       (rd_op),
        .o_alu_sub     (alu_sub),
        .o_csr_op      (csr_op),
        .o_mem_cmd     (mem_cmd),
        .o_op_b_source (op_b_source)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] w, input logic en, input logic nxt);
        dq_if.i_wb_rdt = w[31:2];
        dq_if.i_wb_en  = en;
        dq_if.i_next   = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        dq_if.i_wb_en = 1'b0;
        dq_if.i_next  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(32'h0, 1'b0, 1'b0);
        #2;
        check_eq("rst_valid", {31'd0, dq_if.o_valid}, 32'd0);
        check_eq("rst_ready", {31'd0, dq_if.o_ready}, 32'd1);
        check_eq("rst_level", {30'd0, level}, 32'd0);
        check_eq("rst_ovf",   {31'd0, ovf}, 32'd0);
        #10;
        rst_n = 1'b1;

        // addi: first push, visible after the edge
        drive(W_ADDI, 1'b1, 1'b0);
        #1;
        check_eq("addi_same_cycle_valid", {31'd0, dq_if.o_valid}, {31'd0, BYP});
        tick();
        check_eq("addi_valid",   {31'd0, dq_if.o_valid}, 32'd1);
        check_eq("addi_opcode",  {27'd0, opcode}, 32'h04);
        check_eq("addi_rd_op",   {31'd0, rd_op}, 32'd1);
        check_eq("addi_alu_sub", {31'd0, alu_sub}, 32'd0);
        check_eq("addi_mem_op",  {31'd0, mem_op}, 32'd0);
        check_eq("addi_level",   {30'd0, level}, 32'd1);
        drive(W_ADDI, 1'b0, 1'b1);
        tick();
        check_eq("pop_addi_level", {30'd0, level}, 32'd0);
        check_eq("pop_addi_valid", {31'd0, dq_if.o_valid}, 32'd0);

        // fill with sub, lw
        drive(W_SUB, 1'b1, 1'b0);
        tick();
        drive(W_LW, 1'b1, 1'b0);
        tick();
        check_eq("full_ready",  {31'd0, dq_if.o_ready}, 32'd0);
        check_eq("full_level",  {30'd0, level}, 32'd2);
        check_eq("sub_alu_sub", {31'd0, alu_sub}, 32'd1);
        check_eq("sub_op_b",    {31'd0, op_b_source}, 32'd1);
        check_eq("sub_rd_op",   {31'd0, rd_op}, 32'd1);

        // push beq while popping sub at full
        drive(W_BEQ, 1'b1, 1'b1);
        tick();
        check_eq("fullpp_level", {30'd0, level}, 32'd2);
        check_eq("fullpp_ovf",   {31'd0, ovf}, 32'd0);
        check_eq("lw_mem_op",    {31'd0, mem_op}, 32'd1);
        check_eq("lw_mem_cmd",   {31'd0, mem_cmd}, 32'd0);
        check_eq("lw_funct3",    {29'd0, funct3}, 32'd2);

        // push while full without pop is dropped
        drive(W_SLLI, 1'b1, 1'b0);
        tick();
        check_eq("ovf_set",   {31'd0, ovf}, 32'd1);
        check_eq("ovf_level", {30'd0, level}, 32'd2);
        check_eq("ovf_head_lw", {27'd0, opcode}, 32'h00);

        drive(W_SLLI, 1'b0, 1'b1);
        tick();
        check_eq("beq_branch", {31'd0, branch_op}, 32'd1);
        check_eq("beq_rd_op",  {31'd0, rd_op}, 32'd0);
        check_eq("beq_level",  {30'd0, level}, 32'd1);

        // push+pop at count 1 across pointer wrap
        drive(W_SLLI, 1'b1, 1'b1);
        tick();
        check_eq("cnt1pp_level", {30'd0, level}, 32'd1);
        check_eq("slli_shift",   {31'd0, shift_op}, 32'd1);
        check_eq("slli_slt",     {31'd0, slt_op}, 32'd0);
        check_eq("ovf_sticky",   {31'd0, ovf}, 32'd1);
        drive(W_SLLI, 1'b0, 1'b1);
        tick();
        check_eq("drain_level", {30'd0, level}, 32'd0);

        drive(W_SLTI, 1'b1, 1'b0);
        tick();
        drive(W_CSR, 1'b1, 1'b0);
        tick();
        check_eq("slti_slt",   {31'd0, slt_op}, 32'd1);
        check_eq("slti_shift", {31'd0, shift_op}, 32'd0);
        check_eq("slti_csr",   {31'd0, csr_op}, 32'd0);
        drive(W_CSR, 1'b0, 1'b1);
        tick();
        check_eq("csr_csr_op", {31'd0, csr_op}, 32'd1);
        check_eq("csr_branch", {31'd0, branch_op}, 32'd0);
        check_eq("csr_rd_op",  {31'd0, rd_op}, 32'd1);

        // refill to 2 and reset mid-cycle
        drive(W_ADDI, 1'b1, 1'b0);
        tick();
        check_eq("pre_rst_level", {30'd0, level}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", {31'd0, dq_if.o_valid}, 32'd0);
        check_eq("async_rst_level", {30'd0, level}, 32'd0);
        check_eq("async_rst_ovf",   {31'd0, ovf}, 32'd0);
        check_eq("async_rst_ready", {31'd0, dq_if.o_ready}, 32'd1);
        #1;
        rst_n = 1'b1;
        drive(W_SLTI, 1'b1, 1'b0);
        tick();
        check_eq("post_rst_level", {30'd0, level}, 32'd1);
        check_eq("post_rst_slt",   {31'd0, slt_op}, 32'd1);
        drive(W_SLTI, 1'b0, 1'b1);
        tick();
        check_eq("post_rst_drain", {30'd0, level}, 32'd0);

        // empty queue: push with next in the same cycle
        drive(W_ADDI, 1'b1, 1'b1);
        #1;
        check_eq("byp_valid", {31'd0, dq_if.o_valid}, {31'd0, BYP});
`ifdef SERV_DECODE_BYPASS_EN
        check_eq("byp_opcode", {27'd0, opcode}, 32'h04);
        check_eq("byp_rd_op",  {31'd0, rd_op}, 32'd1);
`endif
        tick();
        check_eq("byp_level", {30'd0, level}, BYP ? 32'd0 : 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no end expected end of test");
        $fatal(1);
    end

endmodule
